exe_stage_p: RTL

Parametrised execute stage for the RISC pipeline and successor to the fixed 8-bit EXE unit. Performs ALU operations on two WIDTH-bit operands and keeps a registered N/Z/C/V flag file with write and clear control. Adds a valid/ready handshake on input and output, and an optional iterative multiply. Sits between the decode/register-read stage and the writeback stage.

---
 rtl/exe_stage_p.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage_p.sv
// exe_stage_p: WIDTH-bit ALU execute stage with valid/ready and N/Z/C/V flags.
// Define EXE_MUL_EN to build the iterative shift-add multiply for op 10.
module exe_stage_p #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flag_we,
  input  logic             flag_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int MSB = WIDTH - 1;

  localparam logic [OPW-1:0] OP_PASSA = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(2);
  localparam logic [OPW-1:0] OP_AND   = OPW'(3);
  localparam logic [OPW-1:0] OP_OR    = OPW'(4);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(5);
  localparam logic [OPW-1:0] OP_NOT   = OPW'(6);
  localparam logic [OPW-1:0] OP_SHL   = OPW'(7);
  localparam logic [OPW-1:0] OP_SHR   = OPW'(8);
  localparam logic [OPW-1:0] OP_ASR   = OPW'(9);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(10);
  localparam logic [OPW-1:0] OP_CMP   = OPW'(11);
  localparam logic [OPW-1:0] OP_ADC   = OPW'(12);
  localparam logic [OPW-1:0] OP_SBB   = OPW'(13);
  localparam logic [OPW-1:0] OP_PASSB = OPW'(14);

`ifdef EXE_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t               state, state_nx;
  logic                 is_mul;
  logic                 mul_done;
  logic                 mul_we;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
`endif

  logic             cin, bin;
  logic [WIDTH:0]   sum, dif;
  logic             v_add, v_sub;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v, alu_upd;
  logic             take, take1;

  assign cin   = (op == OP_ADC) & flag_c;
  assign bin   = (op == OP_SBB) & flag_c;
  assign sum   = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
  assign dif   = {1'b0, opa} - {1'b0, opb} - {{WIDTH{1'b0}}, bin};
  assign v_add = (opa[MSB] == opb[MSB]) && (sum[MSB] != opa[MSB]);
  assign v_sub = (opa[MSB] != opb[MSB]) && (dif[MSB] != opa[MSB]);

`ifdef EXE_MUL_EN
  assign in_ready = rst && (state == S_IDLE) && (!out_valid || out_ready);
  assign mul_done = (state == S_MUL) && (cnt == CW'(WIDTH));
  assign take     = in_valid && in_ready;
  assign take1    = take && !is_mul;
`else
  assign in_ready = rst && (!out_valid || out_ready);
  assign take     = in_valid && in_ready;
  assign take1    = take;
`endif

  // single-cycle ALU result and flag candidates
  always_comb begin
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_upd = 1'b1;
`ifdef EXE_MUL_EN
    is_mul  = 1'b0;
`endif
    unique case (op)
      OP_PASSA: alu_r = opa;
      OP_ADD, OP_ADC: begin
        alu_r = sum[MSB:0];
        alu_c = sum[WIDTH];
        alu_v = v_add;
      end
      OP_SUB, OP_SBB: begin
        alu_r = dif[MSB:0];
        alu_c = dif[WIDTH];
        alu_v = v_sub;
      end
      OP_CMP: begin
        alu_r = opa;
        alu_c = dif[WIDTH];
        alu_v = v_sub;
      end
      OP_AND:   alu_r = opa & opb;
      OP_OR:    alu_r = opa | opb;
      OP_XOR:   alu_r = opa ^ opb;
      OP_NOT:   alu_r = ~opa;
      OP_PASSB: alu_r = opb;
      OP_SHL: begin
        alu_r = {opa[MSB-1:0], 1'b0};
        alu_c = opa[MSB];
      end
      OP_SHR: begin
        alu_r = {1'b0, opa[MSB:1]};
        alu_c = opa[0];
      end
      OP_ASR: begin
        alu_r = {opa[MSB], opa[MSB:1]};
        alu_c = opa[0];
      end
      OP_MUL: begin
`ifdef EXE_MUL_EN
        is_mul  = 1'b1;
`else
        alu_upd = 1'b0;
`endif
      end
      default: alu_upd = 1'b0;
    endcase
  end

`ifdef EXE_MUL_EN
  // multiply FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // multiply FSM next state
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (take && is_mul) state_nx = S_MUL;
      S_MUL:  if (mul_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // shift-add datapath, one multiplier bit per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      mul_we <= 1'b0;
    end else if (take && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, opa};
      acc    <= '0;
      mplier <= opb;
      cnt    <= '0;
      mul_we <= flag_we;
    end else if (state == S_MUL && !mul_done) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end
`endif

  // result, output valid and flag file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result    <= '0;
      out_valid <= 1'b0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      if (take1) begin
        result    <= alu_r;
        out_valid <= 1'b1;
        if (flag_we && alu_upd) begin
          flag_n <= alu_r[MSB];
          flag_z <= (alu_r == '0);
          flag_c <= alu_c;
          flag_v <= alu_v;
        end
      end
`ifdef EXE_MUL_EN
      else if (mul_done) begin
        result    <= acc[MSB:0];
        out_valid <= 1'b1;
        if (mul_we) begin
          flag_n <= acc[MSB];
          flag_z <= (acc[MSB:0] == '0);
          flag_c <= |acc[2*WIDTH-1:WIDTH];
          flag_v <= |acc[2*WIDTH-1:WIDTH];
        end
      end
`endif
      else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (flag_clr) begin
        flag_n <= 1'b0;
        flag_z <= 1'b0;
        flag_c <= 1'b0;
        flag_v <= 1'b0;
      end
    end
  end

endmodule
